// File: rtl/blvds_frame_rx.sv
// BLVDS frame deframer: payload goes into a FIFO speculatively and becomes readable only on a good EOF.
// Optional BLVDS_RX_CHECKSUM_EN builds the EOF checksum compare (error 5); without it the EOF field is ignored.
module blvds_frame_rx #(
    parameter int DEPTH_LOG2 = 10,
    parameter int MAX_LEN    = 512
) (
    input  logic                  iclk,
    input  logic                  ireset_n,
    input  logic [17:0]           iDATA_BLVDS,
    output logic [15:0]           oDATA,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic                  oFRAME_OK,
    output logic                  oFRAME_ERR,
    output logic [2:0]            oERR_CODE,
    output logic [15:0]           oFRAME_CNT,
    output logic [7:0]            oERR_CNT,
    output logic [DEPTH_LOG2:0]   oLEVEL
);
    localparam int               PW       = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]    DEPTH    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [16:0]      MAX_LEN_W = 17'(MAX_LEN);

    localparam logic [1:0] TAG_SOF  = 2'b01;
    localparam logic [1:0] TAG_DATA = 2'b10;
    localparam logic [1:0] TAG_EOF  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP} state_t;

    logic [17:0]   data_q;
    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d, cnt_q, cnt_d;
    logic [PW-1:0] wr_spec_q, wr_spec_d, wr_commit_q, wr_commit_d, rd_q, rd_d;
    logic          ok_q, ok_d, err_q, err_d, vld_q, vld_d;
    logic [2:0]    code_q, code_d;
    logic [15:0]   fcnt_q, fcnt_d, dout_q, dout_d;
    logic [7:0]    ecnt_q, ecnt_d;
`ifdef BLVDS_RX_CHECKSUM_EN
    logic [15:0]   sum_q, sum_d;
`endif

    logic [15:0]   mem [2**DEPTH_LOG2];
    logic          we, take_sof, fail, load, consume;
    logic [2:0]    fail_code, sof_code;
    logic [1:0]    tag;
    logic [15:0]   field;
    logic [PW-1:0] free, fetch_ptr;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        fcnt_d      = fcnt_q;
        ecnt_d      = ecnt_q;
        code_d      = code_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        we          = 1'b0;
        take_sof    = 1'b0;
        fail        = 1'b0;
        fail_code   = 3'd0;
`ifdef BLVDS_RX_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        tag   = data_q[17:16];
        field = data_q[15:0];
        free  = DEPTH - (wr_commit_q - rd_q);

        if (field == 16'd0 || {1'b0, field} > MAX_LEN_W) sof_code = 3'd1;
        else if ({1'b0, field} > 17'(free))               sof_code = 3'd2;
        else                                              sof_code = 3'd0;

        case (state_q)
            S_IDLE: take_sof = (tag == TAG_SOF);
            S_PAYLOAD: begin
                case (tag)
                    TAG_DATA: begin
                        if (cnt_q < len_q) begin
                            we        = 1'b1;
                            wr_spec_d = wr_spec_q + 1'b1;
                            cnt_d     = cnt_q + 16'd1;
`ifdef BLVDS_RX_CHECKSUM_EN
                            sum_d     = sum_q + field;
`endif
                        end else begin
                            fail      = 1'b1;
                            fail_code = 3'd4;
                            state_d   = S_DROP;
                        end
                    end
                    TAG_EOF: begin
                        state_d = S_IDLE;
                        if (cnt_q < len_q) begin
                            fail      = 1'b1;
                            fail_code = 3'd3;
`ifdef BLVDS_RX_CHECKSUM_EN
                        end else if (field != sum_q) begin
                            fail      = 1'b1;
                            fail_code = 3'd5;
`endif
                        end else begin
                            wr_commit_d = wr_spec_q;
                            ok_d        = 1'b1;
                            fcnt_d      = fcnt_q + 16'd1;
                        end
                    end
                    TAG_SOF: begin
                        fail      = 1'b1;
                        fail_code = 3'd6;
                        take_sof  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_DROP: begin
                if (tag == TAG_EOF) state_d = S_IDLE;
                take_sof = (tag == TAG_SOF);
            end
            default: state_d = S_IDLE;
        endcase

        // A bad replacement SOF after an abort reports its own code in the single pulse.
        if (take_sof) begin
            if (sof_code != 3'd0) begin
                fail      = 1'b1;
                fail_code = sof_code;
                state_d   = S_DROP;
            end else begin
                len_d   = field;
                cnt_d   = 16'd0;
                state_d = S_PAYLOAD;
`ifdef BLVDS_RX_CHECKSUM_EN
                sum_d   = 16'd0;
`endif
            end
        end

        if (fail) begin
            err_d     = 1'b1;
            code_d    = fail_code;
            wr_spec_d = wr_commit_q;
            if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
        end
    end

    // Show-ahead output: refill from the next committed slot whenever the holding register frees up.
    always_comb begin
        consume   = vld_q & iREADY;
        rd_d      = rd_q + {{DEPTH_LOG2{1'b0}}, consume};
        fetch_ptr = rd_q + {{DEPTH_LOG2{1'b0}}, vld_q};
        load      = (!vld_q || iREADY) && (fetch_ptr != wr_commit_q);
        vld_d     = vld_q;
        dout_d    = dout_q;
        if (load) begin
            vld_d  = 1'b1;
            dout_d = mem[fetch_ptr[DEPTH_LOG2-1:0]];
        end else if (consume) begin
            vld_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            data_q      <= '0;
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            rd_q        <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
            fcnt_q      <= '0;
            ecnt_q      <= '0;
            vld_q       <= 1'b0;
            dout_q      <= '0;
`ifdef BLVDS_RX_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            data_q      <= iDATA_BLVDS;
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wr_spec_q   <= wr_spec_d;
            wr_commit_q <= wr_commit_d;
            rd_q        <= rd_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            code_q      <= code_d;
            fcnt_q      <= fcnt_d;
            ecnt_q      <= ecnt_d;
            vld_q       <= vld_d;
            dout_q      <= dout_d;
`ifdef BLVDS_RX_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // NOTE: the storage array has no reset; zeroed pointers already make its contents unreachable.
    always_ff @(posedge iclk) begin
        if (we) mem[wr_spec_q[DEPTH_LOG2-1:0]] <= field;
    end

    assign oDATA      = dout_q;
    assign oVALID     = vld_q;
    assign oFRAME_OK  = ok_q;
    assign oFRAME_ERR = err_q;
    assign oERR_CODE  = code_q;
    assign oFRAME_CNT = fcnt_q;
    assign oERR_CNT   = ecnt_q;
    assign oLEVEL     = wr_commit_q - rd_q;
endmodule

// File: tb/tb_blvds_frame_rx.sv
// Scoreboard bench for blvds_frame_rx: stimulus pushes expected words and frame results, a monitor pops and compares.
module tb_blvds_frame_rx;
    localparam int DL = 4;

    logic          iclk = 1'b0;
    logic          ireset_n = 1'b0;
    logic [17:0]   din = '0;
    logic          iREADY = 1'b0;
    logic [15:0]   oDATA;
    logic          oVALID, oFRAME_OK, oFRAME_ERR;
    logic [2:0]    oERR_CODE;
    logic [15:0]   oFRAME_CNT;
    logic [7:0]    oERR_CNT;
    logic [DL:0]   oLEVEL;

    int checks = 0;
    int errors = 0;
    int exp_fcnt = 0;
    int exp_ecnt = 0;
    logic [15:0] exp_data[$];
    logic [2:0]  exp_stat[$];

    blvds_frame_rx #(.DEPTH_LOG2(DL), .MAX_LEN(16)) dut (
        .iclk(iclk), .ireset_n(ireset_n), .iDATA_BLVDS(din),
        .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY),
        .oFRAME_OK(oFRAME_OK), .oFRAME_ERR(oFRAME_ERR), .oERR_CODE(oERR_CODE),
        .oFRAME_CNT(oFRAME_CNT), .oERR_CNT(oERR_CNT), .oLEVEL(oLEVEL)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected DUT event", name);
    endtask

    // Monitor: every handshake and frame pulse must match the head of its queue.
    initial begin
        logic [2:0] got;
        forever begin
            @(negedge iclk);
            if (ireset_n) begin
                if (oVALID && iREADY) begin
                    if (exp_data.size() == 0) note_fail("rd_unexpected");
                    else check("rd_data", oDATA, exp_data.pop_front());
                end
                if (oFRAME_OK && oFRAME_ERR) note_fail("ok_and_err");
                else if (oFRAME_OK || oFRAME_ERR) begin
                    got = oFRAME_ERR ? oERR_CODE : 3'd0;
                    if (exp_stat.size() == 0) note_fail("status_unexpected");
                    else check("frame_status", got, exp_stat.pop_front());
                end
            end
        end
    end

    task automatic put(input logic [1:0] tag, input logic [15:0] f);
        @(posedge iclk);
        #1 din = {tag, f};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(2'b00, 16'h0);
    endtask

    task automatic send_frame(input logic [15:0] len, input int n, input logic [15:0] first,
                              input logic [15:0] delta, input bit eof);
        logic [15:0] sum;
        sum = '0;
        put(2'b01, len);
        for (int i = 0; i < n; i++) begin
            put(2'b10, first + 16'(i));
            sum = sum + first + 16'(i);
        end
        if (eof) put(2'b11, sum + delta);
        put(2'b00, 16'h0);
    endtask

    task automatic expect_ok(input int n, input logic [15:0] first);
        for (int i = 0; i < n; i++) exp_data.push_back(first + 16'(i));
        exp_stat.push_back(3'd0);
        exp_fcnt++;
    endtask

    task automatic expect_err(input logic [2:0] c);
        exp_stat.push_back(c);
        if (exp_ecnt < 255) exp_ecnt++;
    endtask

    task automatic drain(input string name);
        int k;
        idle(4);
        iREADY = 1'b1;
        k = 0;
        while ((oLEVEL != 0 || oVALID) && k < 300) begin
            @(posedge iclk);
            #1 k++;
        end
        if (k >= 300) note_fail({name, "_drain_timeout"});
        idle(2);
        check({name, "_level"}, oLEVEL, 0);
        check({name, "_fcnt"}, oFRAME_CNT, exp_fcnt);
        check({name, "_ecnt"}, oERR_CNT, exp_ecnt);
    endtask

    initial begin
        int k;
        #1;
        check("rst_valid", oVALID, 0);
        check("rst_code", oERR_CODE, 0);
        check("rst_level", oLEVEL, 0);
        check("rst_fcnt", oFRAME_CNT, 0);
        repeat (3) @(posedge iclk);
        #3 ireset_n = 1'b1;

        // Good frame 1,2,3,4 with checksum 0x000A.
        iREADY = 1'b1;
        expect_ok(4, 16'd1);
        send_frame(16'd4, 4, 16'd1, 16'd0, 1'b1);
        drain("good");

        // Checksum off by one, then a good frame 5..8.
`ifdef BLVDS_RX_CHECKSUM_EN
        expect_err(3'd5);
`else
        expect_ok(4, 16'd1);
`endif
        send_frame(16'd4, 4, 16'd1, 16'd1, 1'b1);
        idle(4);
`ifdef BLVDS_RX_CHECKSUM_EN
        check("csum_code", oERR_CODE, 5);
`endif
        expect_ok(4, 16'd5);
        send_frame(16'd4, 4, 16'd5, 16'd0, 1'b1);
        drain("csum");

        // Length faults: overrun, underrun, zero length, over MAX_LEN.
        expect_err(3'd4);
        send_frame(16'd3, 4, 16'h40, 16'd0, 1'b1);
        idle(3);
        check("overrun_code", oERR_CODE, 4);
        expect_err(3'd3);
        send_frame(16'd4, 3, 16'h50, 16'd0, 1'b1);
        idle(3);
        check("underrun_code", oERR_CODE, 3);
        expect_err(3'd1);
        send_frame(16'd0, 2, 16'h60, 16'd0, 1'b1);
        expect_err(3'd1);
        send_frame(16'd17, 2, 16'h70, 16'd0, 1'b1);
        idle(3);
        check("len_code", oERR_CODE, 1);
        check("len_valid", oVALID, 0);
        drain("len");

        // Full FIFO: hold 12 words, LEN=8 rejected, read 4, LEN=8 accepted.
        iREADY = 1'b0;
        expect_ok(12, 16'h100);
        send_frame(16'd12, 12, 16'h100, 16'd0, 1'b1);
        idle(4);
        check("full_level12", oLEVEL, 12);
        check("full_valid", oVALID, 1);
        check("full_head", oDATA, 16'h100);
        expect_err(3'd2);
        send_frame(16'd8, 8, 16'h200, 16'd0, 1'b1);
        idle(3);
        check("full_code", oERR_CODE, 2);
        check("full_level_after_rej", oLEVEL, 12);
        iREADY = 1'b1;
        k = 0;
        do begin
            @(posedge iclk);
            #1 k++;
        end while (oLEVEL != 8 && k < 50);
        iREADY = 1'b0;
        if (k >= 50) note_fail("full_read4_timeout");
        expect_ok(8, 16'h200);
        send_frame(16'd8, 8, 16'h200, 16'd0, 1'b1);
        idle(4);
        check("full_level16", oLEVEL, 16);
        drain("full");

        // Abort by SOF mid-frame, then the new frame commits.
        expect_err(3'd6);
        put(2'b01, 16'd4);
        put(2'b10, 16'h99);
        expect_ok(4, 16'h20);
        send_frame(16'd4, 4, 16'h20, 16'd0, 1'b1);
        idle(3);
        check("abort_code", oERR_CODE, 6);
        drain("abort");

        // Reset in the middle of a payload.
        put(2'b01, 16'd4);
        put(2'b10, 16'h11);
        put(2'b10, 16'h12);
        @(posedge iclk);
        #3 ireset_n = 1'b0;
        din = '0;
        #1;
        check("arst_valid", oVALID, 0);
        check("arst_ok", oFRAME_OK, 0);
        check("arst_err", oFRAME_ERR, 0);
        check("arst_code", oERR_CODE, 0);
        check("arst_fcnt", oFRAME_CNT, 0);
        check("arst_ecnt", oERR_CNT, 0);
        check("arst_level", oLEVEL, 0);
        check("arst_data", oDATA, 0);
        exp_fcnt = 0;
        exp_ecnt = 0;
        repeat (2) @(posedge iclk);
        #3 ireset_n = 1'b1;
        expect_ok(4, 16'h30);
        send_frame(16'd4, 4, 16'h30, 16'd0, 1'b1);
        drain("post_reset");

        check("data_queue_empty", exp_data.size(), 0);
        check("status_queue_empty", exp_stat.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
